// File: rtl/ir_grid_scanner.sv
// Scans a 4x4 IR sensor matrix one row at a time, debounces every sensor
// independently and keeps a sticky map of every box touched since the last clear.
//   clk, resetn (async, active-low)
//   row_drive  : one-hot row enable, bit r drives row r
//   col_sense  : column sense lines, bit c is column c (pre-synchronised)
//   clear      : synchronous clear of traced
//   ir_in      : debounced hit map, bit 4*row+col
//   traced     : sticky OR of ir_in since reset/clear
//   frame_done : one-cycle pulse after the row-3 sample
module ir_grid_scanner #(
  parameter int unsigned SETTLE_CYCLES    = 50,
  parameter int unsigned DEBOUNCE_SCANS   = 4,
  parameter bit          SENSE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [3:0]  row_drive,
  input  logic [3:0]  col_sense,
  input  logic        clear,
  output logic [15:0] ir_in,
  output logic [15:0] traced,
  output logic        frame_done
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    row;
  logic [CW-1:0] settle_cnt;
  logic [DW-1:0] dcnt     [16];
  logic [DW-1:0] dcnt_nxt [16];
  logic [15:0]   ir_nxt;
  logic [3:0]    raw;
  logic [3:0]    bit_idx;
  logic          start_scan;
  logic          settling;
  logic          settle_last;
  logic          sample_en;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    start_scan  = (state == IDLE);
    settling    = (state == SETTLE);
    settle_last = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    sample_en   = (state == SAMPLE);
  end

  // Row sequencing and settle timing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row        <= '0;
      settle_cnt <= '0;
      row_drive  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= sample_en && (row == 2'd3);
      if (start_scan) begin
        row        <= '0;
        row_drive  <= 4'b0001;
        settle_cnt <= '0;
      end else if (sample_en) begin
        row        <= row + 2'd1;
        row_drive  <= 4'b0001 << (row + 2'd1);
        settle_cnt <= '0;
      end else if (settle_last) begin
        settle_cnt <= '0;
      end else if (settling) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  // Debounce: only the four bits of the row being sampled can move
  always_comb begin
    raw      = SENSE_ACTIVE_LOW ? ~col_sense : col_sense;
    ir_nxt   = ir_in;
    dcnt_nxt = dcnt;
    bit_idx  = '0;
    if (sample_en) begin
      for (int unsigned c = 0; c < 4; c++) begin
        bit_idx = {row, c[1:0]};
        if (raw[c] == ir_in[bit_idx]) begin
          dcnt_nxt[bit_idx] = '0;
        end else if (dcnt[bit_idx] == DEB_LAST) begin
          ir_nxt[bit_idx]   = ~ir_in[bit_idx];
          dcnt_nxt[bit_idx] = '0;
        end else begin
          dcnt_nxt[bit_idx] = dcnt[bit_idx] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir_in  <= '0;
      traced <= '0;
      dcnt   <= '{default: '0};
    end else begin
      ir_in  <= ir_nxt;
      dcnt   <= dcnt_nxt;
      traced <= clear ? '0 : (traced | ir_in);
    end
  end

endmodule

// File: tb/tb_ir_grid_scanner.sv
module tb_ir_grid_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  row_drive;
  logic [3:0]  col_sense;
  logic        clear;
  logic [15:0] ir_in;
  logic [15:0] traced;
  logic        frame_done;

  always #5 clk = ~clk;

  ir_grid_scanner #(
    .SETTLE_CYCLES   (3),
    .DEBOUNCE_SCANS  (4),
    .SENSE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .row_drive (row_drive),
    .col_sense (col_sense),
    .clear     (clear),
    .ir_in     (ir_in),
    .traced    (traced),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] tr;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [15:0] hit_map = '0;

  // Sticky-map scenario: boxes 0,5,10,15 held 5 frames each, then 4 idle frames
  localparam logic [15:0] ST_IR [24] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001,
    16'h0001, 16'h0001, 16'h0001, 16'h0020, 16'h0020,
    16'h0020, 16'h0020, 16'h0020, 16'h0400, 16'h0400,
    16'h0400, 16'h0400, 16'h0400, 16'h8000, 16'h8000,
    16'h8000, 16'h8000, 16'h8000, 16'h0000};
  // Row-3 bits reach traced one cycle after frame_done's edge
  localparam logic [15:0] ST_TR [24] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001,
    16'h0001, 16'h0001, 16'h0001, 16'h0021, 16'h0021,
    16'h0021, 16'h0021, 16'h0021, 16'h0421, 16'h0421,
    16'h0421, 16'h0421, 16'h0421, 16'h0421, 16'h8421,
    16'h8421, 16'h8421, 16'h8421, 16'h8421};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wand model: active-low column lines for whichever row is being driven
  task automatic drive_sense();
    logic [3:0] nib;
    nib = '0;
    case (row_drive)
      4'b0001: nib = hit_map[3:0];
      4'b0010: nib = hit_map[7:4];
      4'b0100: nib = hit_map[11:8];
      4'b1000: nib = hit_map[15:12];
      default: nib = '0;
    endcase
    col_sense = ~nib;
  endtask

  task automatic tick();
    @(negedge clk);
    drive_sense();
  endtask

  task automatic wait_fd(output int unsigned cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (frame_done !== 1'b1 && cyc < 40);
  endtask

  task automatic frame(input logic [15:0] hits, input logic [15:0] e_ir,
                       input logic [15:0] e_tr, input string tag);
    int unsigned cyc;
    exp_t e;
    hit_map = hits;
    sb.push_back({e_ir, e_tr});
    wait_fd(cyc);
    check({tag, " period"}, 16'(cyc), 16'd16);
    e = sb.pop_front();
    check({tag, " ir_in"}, ir_in, e.ir);
    check({tag, " traced"}, traced, e.tr);
  endtask

  // First frame after reset release: IDLE cycle, then rows 0..3 held 4 cycles each
  task automatic scan_check(input logic [15:0] e_ir, input logic [15:0] e_tr, input string tag);
    logic [3:0] e_rd;
    exp_t e;
    sb.push_back({e_ir, e_tr});
    for (int unsigned k = 1; k <= 17; k++) begin
      tick();
      e_rd = 4'b0001 << ((k - 1) / 4 % 4);
      check($sformatf("%s row_drive k%0d", tag, k), {12'h000, row_drive}, {12'h000, e_rd});
      check($sformatf("%s frame_done k%0d", tag, k), {15'h0000, frame_done},
            (k == 17) ? 16'd1 : 16'd0);
    end
    e = sb.pop_front();
    check({tag, " ir_in"}, ir_in, e.ir);
    check({tag, " traced"}, traced, e.tr);
  endtask

  task automatic clear_pulse(input logic [15:0] e_after, input string tag);
    clear = 1'b1;
    tick();
    check({tag, " traced cleared"}, traced, 16'h0000);
    clear = 1'b0;
    tick();
    check({tag, " traced after"}, traced, e_after);
  endtask

  task automatic resync(input string tag);
    int unsigned cyc;
    wait_fd(cyc);
    check({tag, " resync"}, {15'h0000, frame_done}, 16'd1);
  endtask

  // Column lines toggle in SETTLE cycles only; idle at every SAMPLE
  task automatic noise_frame(input int unsigned idx);
    int unsigned j;
    exp_t e;
    hit_map = '0;
    sb.push_back({16'h0000, 16'h8000});
    j = 0;
    do begin
      tick();
      j++;
      if (j % 4 != 3) col_sense = (j % 2 == 1) ? 4'h0 : 4'($urandom);
    end while (frame_done !== 1'b1 && j < 40);
    check($sformatf("noise f%0d period", idx), 16'(j), 16'd16);
    e = sb.pop_front();
    check($sformatf("noise f%0d ir_in", idx), ir_in, e.ir);
    check($sformatf("noise f%0d traced", idx), traced, e.tr);
  endtask

  initial begin
    resetn    = 1'b1;
    clear     = 1'b0;
    col_sense = 4'hF;
    #2 resetn = 1'b0;

    // Reset and scan order
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check("rst row_drive", {12'h000, row_drive}, 16'h0000);
      check("rst ir_in", ir_in, 16'h0000);
      check("rst traced", traced, 16'h0000);
      check("rst frame_done", {15'h0000, frame_done}, 16'd0);
    end
    resetn = 1'b1;
    scan_check(16'h0000, 16'h0000, "scan");

    // Glitch rejection: 3 frames of hit then gone
    for (int unsigned f = 0; f < 3; f++) frame(16'h0200, 16'h0000, 16'h0000, "glitch");
    frame(16'h0000, 16'h0000, 16'h0000, "glitch gone");
    frame(16'h0000, 16'h0000, 16'h0000, "glitch gone2");

    // Single hit needs 4 fresh frames
    for (int unsigned f = 0; f < 3; f++) frame(16'h0200, 16'h0000, 16'h0000, "hit");
    frame(16'h0200, 16'h0200, 16'h0200, "hit f4");
    for (int unsigned f = 0; f < 3; f++) frame(16'h0000, 16'h0200, 16'h0200, "release");
    frame(16'h0000, 16'h0000, 16'h0200, "release f4");

    clear_pulse(16'h0000, "clr0");
    resync("clr0");

    // Sticky map
    for (int unsigned f = 0; f < 24; f++)
      frame((f < 20) ? (16'h0001 << (5 * (f / 5))) : 16'h0000, ST_IR[f], ST_TR[f],
            $sformatf("sticky f%0d", f + 1));

    // Hold box 15, then clear while it is still present
    for (int unsigned f = 0; f < 3; f++) frame(16'h8000, 16'h0000, 16'h8421, "box15");
    frame(16'h8000, 16'h8000, 16'h8421, "box15 f4");
    clear_pulse(16'h8000, "clr15");
    resync("clr15");
    for (int unsigned f = 0; f < 3; f++) frame(16'h0000, 16'h8000, 16'h8000, "rel15");
    frame(16'h0000, 16'h0000, 16'h8000, "rel15 f4");

    // Sense activity outside SAMPLE must not touch debounce state
    for (int unsigned f = 0; f < 6; f++) noise_frame(f);
    for (int unsigned f = 0; f < 3; f++) frame(16'h0200, 16'h0000, 16'h8000, "post-noise");
    frame(16'h0200, 16'h0200, 16'h8200, "post-noise f4");

    // Asynchronous reset during row-2 SETTLE
    for (int unsigned j = 0; j < 9; j++) tick();
    check("pre-reset row_drive", {12'h000, row_drive}, 16'h0004);
    check("pre-reset ir_in", ir_in, 16'h0200);
    resetn = 1'b0;
    #1;
    check("async row_drive", {12'h000, row_drive}, 16'h0000);
    check("async ir_in", ir_in, 16'h0000);
    check("async traced", traced, 16'h0000);
    check("async frame_done", {15'h0000, frame_done}, 16'd0);
    tick();
    tick();
    resetn = 1'b1;
    scan_check(16'h0000, 16'h0000, "rescan");
    for (int unsigned f = 0; f < 2; f++) frame(16'h0200, 16'h0000, 16'h0000, "rehit");
    frame(16'h0200, 16'h0200, 16'h0200, "rehit f4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
